// File: rtl/read_resp_packer_pkg.sv
// Shared types and default sizing for the read response packer and its bench.
package read_resp_packer_pkg;

    localparam int unsigned DEF_AXI_IDWIDTH   = 4;
    localparam int unsigned DEF_AXI_USERWIDTH = 1;
    localparam int unsigned DEF_AXI_DATAWIDTH = 64;
    localparam int unsigned DEF_BURST_LENGTH  = 8;
    localparam int unsigned DEF_TAGDEPTH      = 8;
    localparam int unsigned DEF_DEADLOCKCNT   = 1024;
    localparam int unsigned TEST_DEADLOCKCNT  = 16;

    typedef struct packed {
        logic [DEF_AXI_IDWIDTH-1:0]   id;
        logic [DEF_AXI_USERWIDTH-1:0] user;
    } rd_tag_t;

endpackage

// File: rtl/read_resp_packer_if.sv
// Request, DRAM beat and cache response channels of the read response packer.
interface read_resp_packer_if
    import read_resp_packer_pkg::*;
#(
    parameter int unsigned AXI_IDWIDTH   = DEF_AXI_IDWIDTH,
    parameter int unsigned AXI_USERWIDTH = DEF_AXI_USERWIDTH,
    parameter int unsigned AXI_DATAWIDTH = DEF_AXI_DATAWIDTH,
    parameter int unsigned BURST_LENGTH  = DEF_BURST_LENGTH,
    parameter int unsigned TAGDEPTH      = DEF_TAGDEPTH
) ();

    logic                                    req_valid;
    logic                                    req_ready;
    logic [AXI_IDWIDTH-1:0]                  req_id;
    logic [AXI_USERWIDTH-1:0]                req_user;
    logic                                    beat_valid;
    logic                                    beat_ready;
    logic [AXI_DATAWIDTH-1:0]                beat_data;
    logic                                    beat_last;
    logic                                    resp_valid;
    logic                                    resp_ready;
    logic [AXI_IDWIDTH-1:0]                  resp_id;
    logic [AXI_USERWIDTH-1:0]                resp_user;
    logic [AXI_DATAWIDTH*BURST_LENGTH-1:0]   resp_data;
    logic [$clog2(TAGDEPTH):0]               outstanding;
    logic                                    err_orphan;
    logic                                    err_last;
    logic                                    err_timeout;

    modport slave (
        input  req_valid, req_id, req_user, beat_valid, beat_data, beat_last, resp_ready,
        output req_ready, beat_ready, resp_valid, resp_id, resp_user, resp_data, outstanding,
        output err_orphan, err_last, err_timeout
    );

    modport master (
        output req_valid, req_id, req_user, beat_valid, beat_data, beat_last, resp_ready,
        input  req_ready, beat_ready, resp_valid, resp_id, resp_user, resp_data, outstanding,
        input  err_orphan, err_last, err_timeout
    );

endinterface

// File: rtl/resp_tag_fifo.sv
// In-order FIFO of read tags; no push-to-pop bypass, so a pushed tag is visible next cycle.
module resp_tag_fifo
    import read_resp_packer_pkg::*;
#(
    parameter type         tag_t = rd_tag_t,
    parameter int unsigned DEPTH = DEF_TAGDEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  tag_t                   push_tag,
    input  logic                   pop,
    output tag_t                   pop_tag,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    assign pop_tag = mem[rd_ptr_q];
    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/read_resp_packer.sv
// Packs BURST_LENGTH DRAM beats plus the head request tag into one cache read response.
// Optional RESP_TIMEOUT_EN adds a sticky stall watchdog on err_timeout.
module read_resp_packer
    import read_resp_packer_pkg::*;
#(
    parameter int unsigned AXI_IDWIDTH   = DEF_AXI_IDWIDTH,
    parameter int unsigned AXI_USERWIDTH = DEF_AXI_USERWIDTH,
    parameter int unsigned AXI_DATAWIDTH = DEF_AXI_DATAWIDTH,
    parameter int unsigned BURST_LENGTH  = DEF_BURST_LENGTH,
    parameter int unsigned TAGDEPTH      = DEF_TAGDEPTH
`ifdef RESP_TIMEOUT_EN
    , parameter int unsigned DEADLOCKCNT = DEF_DEADLOCKCNT
`endif
) (
    input logic               clk,
    input logic               rst_n,
    read_resp_packer_if.slave bus
);

    localparam int unsigned    CW        = $clog2(BURST_LENGTH);
    localparam int unsigned    OW        = $clog2(TAGDEPTH) + 1;
    localparam logic [CW-1:0]  LAST_SLOT = CW'(BURST_LENGTH - 1);

    typedef struct packed {
        logic [AXI_IDWIDTH-1:0]   id;
        logic [AXI_USERWIDTH-1:0] user;
    } tag_t;

    tag_t    push_tag, head_tag, resp_tag_q;
    logic    push, fifo_full, fifo_empty;
    logic [OW-1:0] count;

    logic [CW-1:0]                                cnt_q;
    logic [BURST_LENGTH-1:0][AXI_DATAWIDTH-1:0]   asm_q, line, resp_data_q;
    logic    resp_valid_q, err_orphan_q, err_last_q;
    logic    at_last, beat_ready, beat_acc, orphan, take, complete;

    resp_tag_fifo #(
        .tag_t (tag_t),
        .DEPTH (TAGDEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_tag (push_tag),
        .pop      (complete),
        .pop_tag  (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    always_comb begin
        at_last    = (cnt_q == LAST_SLOT);
        // Only the completing beat can stall: it needs a free output register.
        beat_ready = !(at_last && resp_valid_q && !bus.resp_ready);
        beat_acc   = bus.beat_valid && beat_ready;
        orphan     = beat_acc && fifo_empty && (cnt_q == '0);
        take       = beat_acc && !orphan;
        complete   = take && at_last;
        line                   = asm_q;
        line[BURST_LENGTH-1]   = bus.beat_data;
    end

    assign push     = bus.req_valid && !fifo_full;
    assign push_tag = '{id: bus.req_id, user: bus.req_user};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            err_orphan_q <= 1'b0;
            err_last_q   <= 1'b0;
        end else begin
            if (take) begin
                asm_q[cnt_q] <= bus.beat_data;
                cnt_q        <= at_last ? '0 : cnt_q + CW'(1);
                if (bus.beat_last != at_last) begin
                    err_last_q <= 1'b1;
                end
            end
            if (orphan) begin
                err_orphan_q <= 1'b1;
            end
            if (complete) begin
                resp_valid_q <= 1'b1;
                resp_tag_q   <= head_tag;
                resp_data_q  <= line;
            end else if (resp_valid_q && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = !fifo_full;
    assign bus.beat_ready  = beat_ready;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_tag_q.id;
    assign bus.resp_user   = resp_tag_q.user;
    assign bus.resp_data   = resp_data_q;
    assign bus.outstanding = count;
    assign bus.err_orphan  = err_orphan_q;
    assign bus.err_last    = err_last_q;

`ifdef RESP_TIMEOUT_EN
    localparam int unsigned   SW        = $clog2(DEADLOCKCNT) + 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(DEADLOCKCNT);

    logic [SW-1:0] stall_q, stall_d;
    logic          err_timeout_q;

    always_comb begin
        stall_d = stall_q;
        if (beat_acc || count == '0) begin
            stall_d = '0;
        end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (stall_d == STALL_MAX) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_timeout_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule
